// File: rtl/mole_round_ctrl.sv
// Whack-a-mole round controller: picks a mole, times the guess window, judges the guess, keeps score.
// Optional feature: define WHACK_SPEEDUP_EN to shrink the window after each correct hit.
module mole_round_ctrl #(
  parameter int unsigned ROUND_CYCLES = 100000000,
  parameter int unsigned GAP_CYCLES   = 50000000,
  parameter int unsigned MAX_ROUNDS   = 16,
  parameter int unsigned SCORE_W      = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic               i_guess_valid,
  input  logic [2:0]         i_guess,
  input  logic [2:0]         i_random,
  output logic [2:0]         o_mole_position,
  output logic [2:0]         o_user_guess,
  output logic               o_user_right,
  output logic               o_user_wrong,
  output logic [SCORE_W-1:0] o_score,
  output logic [7:0]         o_round,
  output logic               o_round_active,
  output logic               o_game_over
);

  localparam int unsigned CNT_MAX = (ROUND_CYCLES > GAP_CYCLES) ? ROUND_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_SHOW = 3'd2,
    S_GAP  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [CNT_W-1:0]   win_len_c;
  logic [2:0]         mole_nxt, guess_nxt;
  logic               right_nxt, wrong_nxt;
  logic [SCORE_W-1:0] score_nxt;
  logic [7:0]         round_nxt;

`ifdef WHACK_SPEEDUP_EN
  localparam int unsigned WIN_STEP = ROUND_CYCLES / 16;
  localparam int unsigned WIN_MIN  = ROUND_CYCLES / 4;

  logic [CNT_W-1:0] win_len, win_nxt;
  logic             start_c;

  assign start_c = i_start && (state == S_IDLE || state == S_DONE);

  // Window shrinks by a fixed step per hit, floored at a quarter of the full window
  always_comb begin
    win_nxt = win_len;
    if (start_c) begin
      win_nxt = CNT_W'(ROUND_CYCLES);
    end else if (right_nxt) begin
      win_nxt = (win_len >= CNT_W'(WIN_MIN + WIN_STEP)) ? win_len - CNT_W'(WIN_STEP)
                                                        : CNT_W'(WIN_MIN);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) win_len <= CNT_W'(ROUND_CYCLES);
    else          win_len <= win_nxt;
  end

  assign win_len_c = win_len;
`else
  assign win_len_c = CNT_W'(ROUND_CYCLES);
`endif

  // State and registered outputs
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state           <= S_IDLE;
      cnt             <= '0;
      o_mole_position <= '0;
      o_user_guess    <= '0;
      o_user_right    <= 1'b0;
      o_user_wrong    <= 1'b0;
      o_score         <= '0;
      o_round         <= '0;
      o_round_active  <= 1'b0;
      o_game_over     <= 1'b0;
    end else begin
      state           <= state_nxt;
      cnt             <= cnt_nxt;
      o_mole_position <= mole_nxt;
      o_user_guess    <= guess_nxt;
      o_user_right    <= right_nxt;
      o_user_wrong    <= wrong_nxt;
      o_score         <= score_nxt;
      o_round         <= round_nxt;
      o_round_active  <= (state_nxt == S_SHOW);
      o_game_over     <= (state_nxt == S_DONE);
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (i_start) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_SHOW;
      S_SHOW:  if (i_guess_valid || cnt == '0) state_nxt = S_GAP;
      S_GAP:   if (cnt == '0) state_nxt = (o_round == 8'(MAX_ROUNDS)) ? S_DONE : S_LOAD;
      S_DONE:  if (i_start) state_nxt = S_LOAD;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output and counter next values; a guess beats a same-cycle timeout
  always_comb begin
    cnt_nxt   = cnt;
    mole_nxt  = o_mole_position;
    guess_nxt = o_user_guess;
    right_nxt = 1'b0;
    wrong_nxt = 1'b0;
    score_nxt = o_score;
    round_nxt = o_round;
    case (state)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          score_nxt = '0;
          round_nxt = '0;
        end
      end
      S_LOAD: begin
        mole_nxt = (i_random == o_mole_position) ? o_mole_position + 3'd1 : i_random;
        cnt_nxt  = win_len_c - CNT_W'(1);
      end
      S_SHOW: begin
        if (i_guess_valid || cnt == '0) begin
          cnt_nxt   = CNT_W'(GAP_CYCLES - 1);
          round_nxt = o_round + 8'd1;
          if (i_guess_valid) begin
            guess_nxt = i_guess;
            if (i_guess == o_mole_position) begin
              right_nxt = 1'b1;
              if (o_score != SCORE_MAX) score_nxt = o_score + SCORE_W'(1);
            end else begin
              wrong_nxt = 1'b1;
            end
          end else begin
            wrong_nxt = 1'b1;
          end
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      S_GAP: begin
        if (cnt != '0) cnt_nxt = cnt - CNT_W'(1);
      end
      default: ;
    endcase
  end

endmodule
